// File: rtl/ct_compare_if.sv
// ct_compare_if: word-pair stream between operand source and ct_compare.
// Master drives a valid word pair; slave answers with word_ready_o.
interface ct_compare_if #(
    parameter int WIDTH = 32
);
    logic             word_valid_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             word_ready_o;

    modport master (
        output word_valid_i,
        output a_i,
        output b_i,
        input  word_ready_o
    );

    modport slave (
        input  word_valid_i,
        input  a_i,
        input  b_i,
        output word_ready_o
    );
endinterface

// File: rtl/ct_compare.sv
// ct_compare: constant-time multi-word EQ/NE/LTU/LT comparator, MSW first.
// Define CT_COMPARE_MISMATCH_CNT_EN to add the mism_cnt_o mismatch counter.
module ct_compare #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [1:0]       mode_i,
    ct_compare_if.slave      wd,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rd_o
`ifdef CT_COMPARE_MISMATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] mism_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] M_EQ  = 2'b00;
    localparam logic [1:0] M_NE  = 2'b01;
    localparam logic [1:0] M_LTU = 2'b10;
    localparam logic [1:0] M_LT  = 2'b11;

    localparam logic [CNT_W-1:0] C_MAXW = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic             r_first;
    logic             r_diff;
    logic             r_dec;
    logic             r_lt;
    logic [WIDTH-1:0] r_rd;

    logic [CNT_W-1:0] w_len;
    logic             w_start;
    logic             w_hs;
    logic             w_ready;
    logic             w_neq;
    logic             w_lt_word;
    logic             w_diff_n;
    logic             w_dec_n;
    logic             w_lt_n;
    logic [1:0]       w_mode_n;
    logic             w_bit;
    logic             w_enter_done;

    assign w_len = (len_i > C_MAXW) ? C_MAXW : len_i;

    // Every word is evaluated fully; only register values depend on data.
    assign w_neq = |(wd.a_i ^ wd.b_i);
    assign w_lt_word = (r_mode == M_LT && r_first)
                     ? ($signed(wd.a_i) < $signed(wd.b_i))
                     : (wd.a_i < wd.b_i);

    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_hs      = 1'b0;
        w_ready   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start   = 1'b1;
                    w_state_n = (w_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_ready = 1'b1;
                w_hs    = wd.word_valid_i;
                if (w_hs && r_cnt == C_ONE) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_diff_n = r_diff;
        w_dec_n  = r_dec;
        w_lt_n   = r_lt;
        w_mode_n = r_mode;
        if (w_start) begin
            w_diff_n = 1'b0;
            w_dec_n  = 1'b0;
            w_lt_n   = 1'b0;
            w_mode_n = mode_i;
        end else if (w_hs) begin
            w_diff_n = r_diff | w_neq;
            w_dec_n  = r_dec | w_neq;
            w_lt_n   = (!r_dec && w_neq) ? w_lt_word : r_lt;
        end
    end

    always_comb begin
        w_bit = 1'b0;
        unique case (w_mode_n)
            M_EQ:    w_bit = ~w_diff_n;
            M_NE:    w_bit = w_diff_n;
            M_LTU:   w_bit = w_lt_n;
            M_LT:    w_bit = w_lt_n;
            default: w_bit = 1'b0;
        endcase
    end

    assign w_enter_done = (w_state_n == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_mode  <= M_EQ;
            r_first <= 1'b0;
            r_diff  <= 1'b0;
            r_dec   <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_mode <= w_mode_n;
            r_diff <= w_diff_n;
            r_dec  <= w_dec_n;
            r_lt   <= w_lt_n;
            if (w_start) begin
                r_cnt   <= w_len;
                r_first <= 1'b1;
            end else if (w_hs) begin
                r_cnt   <= r_cnt - C_ONE;
                r_first <= 1'b0;
            end
        end
    end

    // Result is zero-extended; cleared on start, set on DONE entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd <= '0;
        end else if (w_enter_done) begin
            r_rd <= {{(WIDTH-1){1'b0}}, w_bit};
        end else if (w_start) begin
            r_rd <= '0;
        end
    end

`ifdef CT_COMPARE_MISMATCH_CNT_EN
    logic [CNT_W-1:0] r_mcnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcnt <= '0;
        end else if (w_start) begin
            r_mcnt <= '0;
        end else if (w_hs && w_neq) begin
            r_mcnt <= r_mcnt + C_ONE;
        end
    end

    assign mism_cnt_o = r_mcnt;
`endif

    assign wd.word_ready_o = w_ready;
    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);
    assign rd_o            = r_rd;

endmodule

// File: tb/tb_ct_compare.sv
// tb_ct_compare: table vectors, random compares against a wide-integer
// model, and reset/abort sequences for ct_compare.
module tb_ct_compare;

    localparam int CW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic [1:0]    mode_i;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   rd_o;
`ifdef CT_COMPARE_MISMATCH_CNT_EN
    logic [CW-1:0] mism;
`endif

    ct_compare_if #(.WIDTH(32)) wif ();

    ct_compare #(
        .WIDTH(32),
        .MAX_WORDS(16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .len_i   (len_i),
        .mode_i  (mode_i),
        .wd      (wif),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .rd_o    (rd_o)
`ifdef CT_COMPARE_MISMATCH_CNT_EN
        ,
        .mism_cnt_o (mism)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] va [32];
    logic [31:0] vb [32];

    typedef struct packed {
        logic [1:0]       md;
        logic [4:0]       ln;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [31:0]      vmask;
        logic             exp;
        logic [7:0]       lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] md, input int ln,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3,
                       input logic [31:0] b0, input logic [31:0] b1,
                       input logic [31:0] b2, input logic [31:0] b3,
                       input logic [31:0] vm, input logic ex,
                       input int lat);
        vec_t v;
        v.md    = md;
        v.ln    = ln[4:0];
        v.a[0]  = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0]  = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.vmask = vm;
        v.exp   = ex;
        v.lat   = lat[7:0];
        tbl.push_back(v);
    endtask

    // Operands as one big MSW-first integer; LT is a signed compare of it.
    function automatic logic model(input logic [1:0] md, input int n,
                                   output int mc);
        logic [511:0] A;
        logic [511:0] B;
        logic         r;
        A  = '0;
        B  = '0;
        mc = 0;
        for (int i = 0; i < n; i++) begin
            A[511-32*i -: 32] = va[i];
            B[511-32*i -: 32] = vb[i];
            if (va[i] != vb[i]) mc++;
        end
        case (md)
            2'd0:    r = (A == B);
            2'd1:    r = (A != B);
            2'd2:    r = (A < B);
            default: r = ($signed(A) < $signed(B));
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input int n, input logic [31:0] m);
        int k;
        k = 0;
        if (n == 0) return 1;
        for (int c = 1; c <= 100; c++) begin
            if (m[(c-1)%32]) k++;
            if (k == n) return c + 1;
        end
        return -2;
    endfunction

    // Called at posedge+1 with DUT idle; returns at posedge+1 after done.
    task automatic do_cmp(input logic [1:0] md, input int ln,
                          input logic [31:0] vm, input bit poke,
                          output logic [31:0] res, output int lat,
                          output int hs, output int mc,
                          output logic rdy_ok, output logic busy_after);
        int idx;
        res    = '1;
        lat    = -1;
        hs     = 0;
        mc     = -1;
        rdy_ok = 1'b1;
        start_i = 1'b1;
        len_i   = ln[CW-1:0];
        mode_i  = md;
        wif.word_valid_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            idx = (hs < 32) ? hs : 31;
            wif.word_valid_i = vm[(c-1)%32];
            wif.a_i = va[idx];
            wif.b_i = vb[idx];
            start_i = (poke && c == 2);
            @(negedge clk_i);
            if (done_o) begin
                lat = c;
                res = rd_o;
`ifdef CT_COMPARE_MISMATCH_CNT_EN
                mc = int'(mism);
`endif
                break;
            end
            if (!wif.word_ready_o) rdy_ok = 1'b0;
            if (wif.word_ready_o && wif.word_valid_i) hs++;
            @(posedge clk_i); #1;
        end
        wif.word_valid_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        busy_after = busy_o;
    endtask

    task automatic run_check(input string nm, input logic [1:0] md,
                             input int ln, input logic [31:0] vm,
                             input bit poke, input logic ex,
                             input int elat);
        logic [31:0] res;
        int          lat;
        int          hs;
        int          mc;
        int          emc;
        int          n;
        logic        rdy_ok;
        logic        ba;
        logic        mres;
        n    = (ln > 16) ? 16 : ln;
        mres = model(md, n, emc);
        do_cmp(md, ln, vm, poke, res, lat, hs, mc, rdy_ok, ba);
        chk({nm, "_rd"}, 64'(res), 64'({31'b0, ex}));
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_hs"}, 64'(hs), 64'(n));
        chk({nm, "_idle"}, 64'(ba), 64'(0));
        if (n > 0) chk({nm, "_rdy"}, 64'(rdy_ok), 64'(1));
        if (mres !== ex) chk({nm, "_tbl"}, 64'(mres), 64'(ex));
`ifdef CT_COMPARE_MISMATCH_CNT_EN
        chk({nm, "_mc"}, 64'(mc), 64'(emc));
`else
        if (mc != -1) chk({nm, "_mc"}, 64'(mc), 64'(-1));
`endif
    endtask

    initial begin
        int   seen;
        int   ln;
        int   n;
        int   emc;
        logic ex;
        logic [1:0]  md;
        logic [31:0] vm;

        rst_i   = 1'b1;
        start_i = 1'b0;
        len_i   = '0;
        mode_i  = '0;
        wif.word_valid_i = 1'b0;
        wif.a_i = '0;
        wif.b_i = '0;
        for (int i = 0; i < 32; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end

        repeat (2) @(negedge clk_i);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_rdy", 64'(wif.word_ready_o), 64'(0));
        chk("rst_rd", 64'(rd_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // md, len, a0..a3, b0..b3, valid mask, expected bit, done cycle
        add(0, 4, 32'hDEADBEEF, 0, 1, 32'hFFFFFFFF,
                  32'hDEADBEEF, 0, 1, 32'hFFFFFFFF, '1, 1, 5);
        add(0, 4, 32'hDEADBEEF, 0, 1, 32'hFFFFFFFF,
                  32'hDEADBEEE, 0, 1, 32'hFFFFFFFF, '1, 0, 5);
        add(0, 4, 32'hDEADBEEF, 0, 1, 32'hFFFFFFFF,
                  32'hDEADBEEF, 0, 1, 32'hFFFFFFFE, '1, 0, 5);
        add(2, 2, 32'h1, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 0, 0, '1, 0, 3);
        add(3, 2, 32'h80000000, 0, 0, 0, 32'h1, 0, 0, 0, '1, 1, 3);
        add(2, 2, 32'h80000000, 0, 0, 0, 32'h1, 0, 0, 0, '1, 0, 3);
        add(0, 0, 1, 2, 3, 4, 5, 6, 7, 8, '1, 1, 1);
        add(1, 0, 1, 2, 3, 4, 5, 6, 7, 8, '1, 0, 1);
        add(2, 0, 1, 2, 3, 4, 5, 6, 7, 8, '1, 0, 1);
        add(3, 0, 1, 2, 3, 4, 5, 6, 7, 8, '1, 0, 1);
        add(1, 4, 7, 7, 7, 7, 7, 7, 8, 7, '1, 1, 5);
        add(1, 4, 7, 7, 7, 7, 7, 7, 7, 7, '1, 0, 5);
        add(2, 3, 5, 1, 9, 0, 5, 2, 0, 0, '1, 1, 4);
        add(3, 2, 0, 32'h80000000, 0, 0, 0, 32'h1, 0, 0, '1, 0, 3);
        add(0, 3, 4, 5, 6, 0, 4, 5, 6, 0, 32'hFFFFFFFD, 1, 5);

        foreach (tbl[i]) begin
            for (int w = 0; w < 4; w++) begin
                va[w] = tbl[i].a[w];
                vb[w] = tbl[i].b[w];
            end
            run_check($sformatf("tbl%0d", i), tbl[i].md, int'(tbl[i].ln),
                      tbl[i].vmask, 1'b0, tbl[i].exp, int'(tbl[i].lat));
        end

        // len above MAX_WORDS saturates; words 16+ differ but must not count
        for (int i = 0; i < 32; i++) begin
            va[i] = 32'h1000 + i;
            vb[i] = (i < 16) ? va[i] : ~va[i];
        end
        run_check("sat31", 2'd0, 31, '1, 1'b0, 1'b1, 17);

        // start pulse during RUN is ignored
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'h55 * i;
            vb[i] = va[i];
        end
        vb[2] = 32'h0;
        run_check("poke", 2'd1, 4, '1, 1'b1, 1'b1, 5);

        for (int t = 0; t < 40; t++) begin
            md = 2'($urandom_range(0, 3));
            ln = $urandom_range(0, 20);
            vm = $urandom | 32'h11111111;
            for (int i = 0; i < 32; i++) begin
                va[i] = $urandom;
                case ($urandom_range(0, 3))
                    0:       vb[i] = $urandom;
                    1:       vb[i] = va[i] ^ 32'h80000000;
                    default: vb[i] = va[i];
                endcase
            end
            n  = (ln > 16) ? 16 : ln;
            ex = model(md, n, emc);
            run_check($sformatf("rnd%0d", t), md, ln, vm, 1'b0,
                      ex, exp_lat(n, vm));
        end

        // reset after 2 of 4 words aborts the compare with no done
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'hA0 + i;
            vb[i] = va[i];
        end
        start_i = 1'b1;
        len_i   = 5'd4;
        mode_i  = 2'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wif.word_valid_i = 1'b1;
        wif.a_i = va[0];
        wif.b_i = vb[0];
        @(posedge clk_i); #1;
        wif.a_i = va[1];
        wif.b_i = vb[1];
        @(posedge clk_i); #2;
        chk("pre_rst_busy", 64'(busy_o), 64'(1));
        rst_i = 1'b1;
        #1;
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_rd", 64'(rd_o), 64'(0));
        chk("abort_rdy", 64'(wif.word_ready_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        chk("abort_nodone", 64'(seen), 64'(0));
        wif.word_valid_i = 1'b0;
        @(posedge clk_i); #1;
        run_check("post_rst", 2'd0, 4, '1, 1'b0, 1'b1, 5);

        vb[1] = 32'h0;
        vb[3] = 32'h0;
        run_check("two_mism", 2'd1, 4, '1, 1'b0, 1'b1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ct_compare.md
# ct_compare

Constant-time multi-word comparator for the CPU's security datapath: tag/MAC checks and key-slot compares. Operands arrive as word pairs over a valid/ready stream, most-significant word first. The block accumulates the comparison over all words without early exit, so run length depends only on the programmed word count. It generalises the single-word set-equal unit with parametrised width and depth, four compare modes and a sequenced handshake, and returns the result in the same zero-extended register format.

## Interface
- WIDTH, 32: word width in bits and width of rd_o.
- MAX_WORDS, 16: maximum words per compare; CNT_W = $clog2(MAX_WORDS+1).
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- start_i  in  1  begin compare; sampled only in IDLE.
- len_i  in  CNT_W  word count, sampled with start_i; values above MAX_WORDS saturate to MAX_WORDS.
- mode_i  in  2  compare mode, sampled with start_i:
  - 00 EQ
  - 01 NE
  - 10 LTU (unsigned lexicographic)
  - 11 LT (first word signed, remaining words unsigned)
- word_valid_i  in  1  a_i/b_i hold a valid word pair.
- a_i, b_i  in  WIDTH  operand words, MSW first.
- word_ready_o  out  1  block accepts a word this cycle.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse, result valid.
- rd_o  out  WIDTH  result, {WIDTH-1 zeros, bit}; held until the next accepted start.

## Operation
- States:
  - IDLE: start_i=1 latches len (saturated), mode, and clears the accumulators. Goes to RUN, or to DONE if len=0.
  - RUN: word_ready_o=1. Each word_valid_i&word_ready_o handshake consumes one pair and decrements the remaining count. The handshake that brings the count to 0 goes to DONE.
  - DONE: done_o=1 and rd_o updates on the entry edge. Returns to IDLE next cycle.
- Accumulators, all updated on every handshake regardless of prior results:
  - diff |= |(a_i ^ b_i).
  - decided: set at the first word with a_i != b_i.
  - lt: captured only on that first differing word. For LT mode on word 0 it uses the signed compare; otherwise it uses the unsigned compare.
- Result bit:
  - EQ = ~diff
  - NE = diff
  - LTU and LT = lt (0 if all words are equal)
- len=0 gives EQ→1, NE→0, LTU/LT→0.
- start_i outside IDLE is ignored; a compare cannot be aborted except by rst_i.
- word_valid_i outside RUN is ignored and no word is consumed.
- No data-dependent control path: the state sequence and cycle count are independent of operand values.

## Timing
- Reset values: state IDLE, word_ready_o=0, busy_o=0, done_o=0, rd_o=0, all accumulators 0.
- Start at edge t gives RUN (ready high) from t+1.
- With back-to-back valid, a compare of N words has its last handshake at edge t+N. done_o is high in cycle t+N+1, and rd_o is valid from the same edge.
- len=0 gives done_o in cycle t+1.
- Gaps in word_valid_i stall the block in RUN with no timeout.
- busy_o is high from t+1 through the done cycle inclusive.
- A new start is accepted in the first IDLE cycle after done, so the minimum period is N+2 cycles.
- rst_i asserted mid-compare forces IDLE immediately and clears rd_o. The interrupted compare produces no done_o.

## Configuration
- CT_COMPARE_MISMATCH_CNT_EN defined:
  - Adds output mism_cnt_o [CNT_W], which counts the word pairs with a_i != b_i in the current compare.
  - The counter clears on accepted start and on reset, and is valid together with rd_o and held with it.
  - Counter updates must not alter the timing above.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- EQ, len=4, words a=b={DEADBEEF,0,1,FFFFFFFF}, valid back-to-back → done_o in cycle t+5, rd_o=1.
- EQ with a mismatch only in word 0, then repeated with a mismatch only in word 3 → rd_o=0 both times, done_o in the same cycle t+5 both times (constant time).
- LTU, len=2, a={00000001,00000000}, b={00000000,FFFFFFFF} → rd_o=0. LT with a={80000000,0}, b={00000001,0} → rd_o=1.
- len=0 in each mode → done_o at t+1, rd_o = 1 (EQ), 0 (NE, LTU, LT). len=31 with MAX_WORDS=16 → exactly 16 handshakes consumed.
- word_valid_i toggling 1-0-1 for len=3 → ready held, done_o one cycle after the third handshake. A start_i pulse during RUN is ignored.
- rst_i pulse after 2 of 4 words → busy_o=0, rd_o=0, no done_o. A following EQ compare of equal words → rd_o=1. With the macro defined, two mismatched words → mism_cnt_o=2.
